psum_accumulator: RTL

Signed partial-sum accumulator that sits directly downstream of the DRUM approximate multiplier in the PE datapath. It consumes one signed product per accepted beat and sums a run-time-programmable number of products into a wide accumulator. It then presents the finished partial sum on a valid/ready output port and holds it until the consumer takes it. Overflow is either wrapped or saturated, selected at compile time, and is always flagged.

---
 rtl/psum_accumulator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/psum_accumulator.sv
// psum_accumulator
//
// Signed partial-sum accumulator fed by the DRUM approximate multiplier.
// Each accepted product beat is sign-extended and added into a wide
// accumulator. Once the programmed number of terms has been summed, the
// result is held on a valid/ready output port until the consumer takes it.
//
// Compile-time option:
//   SATURATE_EN  defined   -> accumulator clamps to the signed AW-bit range
//                             on overflow
//                undefined -> accumulator wraps modulo 2^AW
//   out_ovf flags any overflow in both builds.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; aborts any sum in progress
//   len        terms per partial sum, sampled on the first beat (0 acts as 1)
//   in_valid   product beat valid
//   in_ready   accumulator can accept a beat (IDLE or ACC)
//   in_prod    signed PW-bit product
//   out_valid  finished partial sum available (DONE)
//   out_ready  consumer takes the partial sum
//   out_psum   signed AW-bit partial sum
//   out_ovf    overflow occurred while forming out_psum
//   busy       a sum is being formed or waiting to be taken

module psum_accumulator #(
    parameter int PW = 32,
    parameter int AW = 40,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_psum,
    output logic          out_ovf,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;
    logic [LW-1:0] rem;
    logic [LW-1:0] rem_next;
    logic          ovf;
    logic          ovf_next;

    logic [AW-1:0] prod_ext;
    logic [AW-1:0] add_sum;
    logic [AW-1:0] add_result;
    logic          add_ovf;
    logic [LW-1:0] len_m1;

    // Size cast of a signed operand sign-extends, and stays legal when AW == PW.
    assign prod_ext = AW'($signed(in_prod));
    assign add_sum  = acc + prod_ext;

    // Two's-complement overflow: operands agree in sign but the result does not.
    assign add_ovf = (acc[AW-1] == prod_ext[AW-1]) && (add_sum[AW-1] != acc[AW-1]);

`ifdef SATURATE_EN
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    // Overflow direction follows the shared operand sign, so acc's sign picks the rail.
    assign add_result = add_ovf ? (acc[AW-1] ? ACC_MIN : ACC_MAX) : add_sum;
`else
    assign add_result = add_sum;
`endif

    // A length of zero is treated as a single-term sum.
    assign len_m1 = (len == '0) ? '0 : len - LW'(1);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            rem   <= rem_next;
            ovf   <= ovf_next;
        end
    end

    // Next-state and handshake decode. in_ready/out_valid depend on state only.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        rem_next   = rem;
        ovf_next   = ovf;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_next   = prod_ext;
                    rem_next   = len_m1;
                    ovf_next   = 1'b0;
                    state_next = (len_m1 == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_next = add_result;
                    ovf_next = ovf | add_ovf;
                    rem_next = rem - LW'(1);
                    if (rem == LW'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign out_psum = acc;
    assign out_ovf  = ovf;
    assign busy     = (state != IDLE);

endmodule
